// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the DMEM arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration in dmem_arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int STARVE_CNT_W     = 8;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } own_state_t;

endpackage

// File: rtl/dmem_arb_rdret.sv
// Read-return steering: remembers who issued the last read and routes the
// 1-cycle-latency DMEM read data back to that requester. Each requester's
// rdata holds its last returned word until its next read returns.
module dmem_arb_rdret
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_issue,
    input  req_t              rd_src,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic              rd_pending;
    req_t              rd_owner;
    logic [DATA_W-1:0] core_hold;
    logic [DATA_W-1:0] dbg_hold;
    logic              core_ret;
    logic              dbg_ret;

    assign core_ret = rd_pending && (rd_owner == REQ_CORE);
    assign dbg_ret  = rd_pending && (rd_owner == REQ_DBG);

    // Track the outstanding read and latch returned data for holding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= REQ_CORE;
            core_hold  <= '0;
            dbg_hold   <= '0;
        end else begin
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_owner <= rd_src;
            end
            if (core_ret) begin
                core_hold <= mem_rdata;
            end
            if (dbg_ret) begin
                dbg_hold <= mem_rdata;
            end
        end
    end

    // Present live memory data on the return cycle, held data otherwise.
    always_comb begin
        core_rvalid = core_ret;
        dbg_rvalid  = dbg_ret;
        core_rdata  = core_ret ? mem_rdata : core_hold;
        dbg_rdata   = dbg_ret  ? mem_rdata : dbg_hold;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (core / debug) in front of the single-port DMEM.
// Default build: fixed core priority with a starvation guard for dbg.
// Build option DMEM_ARB_RR_EN: round-robin between the two requesters.
// The dbg lock behaves the same in both builds.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | no lock held, normal arbitration
// ST_LOCKED | dbg owns DMEM until dbg_lock drops
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    own_state_t state;
    own_state_t state_nxt;
    logic       lock_hold;
    logic       dbg_wins;
    logic       rd_issue;
    req_t       rd_src;

`ifdef DMEM_ARB_RR_EN
    req_t last_gnt;
    logic gnt_seen;
`else
    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);
    logic [STARVE_CNT_W-1:0] starve_cnt;
`endif

    // Owner state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision and next owner state. Grants are forced low while reset
    // is asserted so the outputs read zero even if requests are still high.
    // A locked cycle with dbg_lock already low arbitrates as if idle.
    always_comb begin
        core_gnt  = 1'b0;
        dbg_gnt   = 1'b0;
        state_nxt = state;
        lock_hold = (state == ST_LOCKED) && dbg_lock;
`ifdef DMEM_ARB_RR_EN
        // Until the first grant after reset, core takes the contested slot.
        dbg_wins  = gnt_seen && (last_gnt == REQ_CORE);
`else
        dbg_wins  = (starve_cnt == STARVE_MAX);
`endif
        if (reset) begin
            if (lock_hold) begin
                dbg_gnt = dbg_req;
            end else if (core_req && dbg_req) begin
                dbg_gnt  = dbg_wins;
                core_gnt = !dbg_wins;
            end else begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req;
            end
        end
        case (state)
            ST_IDLE: begin
                if (dbg_gnt && dbg_lock) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!dbg_lock) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef DMEM_ARB_RR_EN
    // Remember who was granted last for round-robin alternation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= REQ_CORE;
            gnt_seen <= 1'b0;
        end else if (core_gnt || dbg_gnt) begin
            last_gnt <= dbg_gnt ? REQ_DBG : REQ_CORE;
            gnt_seen <= 1'b1;
        end
    end
`else
    // Count consecutive denied dbg cycles, saturating at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (dbg_gnt || !dbg_req) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    // Steer the granted requester onto the DMEM port; idle port reads zero.
    always_comb begin
        mem_en    = core_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_issue  = 1'b0;
        rd_src    = REQ_CORE;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            rd_issue  = !core_we;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            rd_issue  = !dbg_we;
            rd_src    = REQ_DBG;
        end
    end

    dmem_arb_rdret #(
        .DATA_W (DATA_W)
    ) u_rdret (
        .clk         (clk),
        .reset       (reset),
        .rd_issue    (rd_issue),
        .rd_src      (rd_src),
        .mem_rdata   (mem_rdata),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (default fixed-priority build) with a small
// behavioural DMEM model attached to the mem_* port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dmem [0:63];
    logic        load_en = 1'b0;
    logic [5:0]  load_idx = '0;
    logic [31:0] load_val = '0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [31:0] caddr;
        logic [31:0] cwdata;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        dlock;
        logic        cg;
        logic        dg;
        logic        men;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        crv;
        logic [31:0] crd;
        logic        drv;
        logic [31:0] drd;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_lock    (dbg_lock),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // DMEM model: preload port, synchronous write, 1-cycle read latency.
    always @(posedge clk) begin
        if (load_en) begin
            dmem[load_idx] <= load_val;
        end else if (mem_en) begin
            if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= dmem[mem_addr[7:2]];
        end
    end

    function automatic logic [133:0] pack_outs();
        return {core_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                core_rvalid, core_rdata, dbg_rvalid, dbg_rdata};
    endfunction

    function automatic logic [133:0] pack_exp(input vec_t v);
        return {v.cg, v.dg, v.men, v.mwe, v.maddr, v.mwdata,
                v.crv, v.crd, v.drv, v.drd};
    endfunction

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        core_req   = v.creq;
        core_we    = v.cwe;
        core_addr  = v.caddr;
        core_wdata = v.cwdata;
        dbg_req    = v.dreq;
        dbg_we     = v.dwe;
        dbg_addr   = v.daddr;
        dbg_wdata  = v.dwdata;
        dbg_lock   = v.dlock;
    endtask

    initial begin
        vec_t v;
        vec_t idle_v;
        logic [1:0] exp_g;

        // creq cwe caddr cwdata | dreq dwe daddr dwdata dlock | cg dg men mwe maddr mwdata | crv crd drv drd
        vecs[0]  = '{1'b0,1'b0,32'h00,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h00,32'h00, 1'b0,32'h00,1'b0,32'h00};
        vecs[1]  = '{1'b1,1'b0,32'h10,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b0,32'h10,32'h00, 1'b0,32'h00,1'b0,32'h00};
        vecs[2]  = '{1'b0,1'b0,32'h00,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h00,32'h00, 1'b1,32'h2a,1'b0,32'h00};
        vecs[3]  = '{1'b1,1'b0,32'h04,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b0,32'h04,32'h00, 1'b0,32'h2a,1'b0,32'h00};
        vecs[4]  = '{1'b0,1'b0,32'h00,32'h00, 1'b1,1'b0,32'h8,32'h0,1'b0, 1'b0,1'b1,1'b1,1'b0,32'h08,32'h00, 1'b1,32'h44,1'b0,32'h00};
        vecs[5]  = '{1'b0,1'b0,32'h00,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h00,32'h00, 1'b0,32'h44,1'b1,32'h88};
        vecs[6]  = '{1'b1,1'b1,32'h20,32'h55, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b1,32'h20,32'h55, 1'b0,32'h44,1'b0,32'h88};
        vecs[7]  = '{1'b1,1'b0,32'h20,32'h00, 1'b1,1'b0,32'hc,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b0,32'h20,32'h00, 1'b0,32'h44,1'b0,32'h88};
        vecs[8]  = '{1'b0,1'b0,32'h00,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h00,32'h00, 1'b1,32'h55,1'b0,32'h88};
        vecs[9]  = '{1'b0,1'b0,32'h00,32'h00, 1'b1,1'b1,32'h0,32'h7,1'b1, 1'b0,1'b1,1'b1,1'b1,32'h00,32'h07, 1'b0,32'h55,1'b0,32'h88};
        vecs[10] = '{1'b1,1'b0,32'h00,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h00,32'h00, 1'b0,32'h55,1'b0,32'h88};
        vecs[11] = vecs[10];
        vecs[12] = vecs[10];
        vecs[13] = '{1'b1,1'b0,32'h00,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b0,32'h00,32'h00, 1'b0,32'h55,1'b0,32'h88};
        vecs[14] = '{1'b0,1'b0,32'h00,32'h00, 1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h00,32'h00, 1'b1,32'h07,1'b0,32'h88};
        idle_v = vecs[0];

        // Reset with both requests high: outputs must all read zero.
        drive(idle_v);
        core_req = 1'b1;
        dbg_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_en  = 1'b1;
            load_idx = (i == 0) ? 6'd4 : (i == 1) ? 6'd1 : 6'd2;
            load_val = (i == 0) ? 32'h2a : (i == 1) ? 32'h44 : 32'h88;
        end
        @(negedge clk);
        load_en = 1'b0;
        #1;
        check("reset_outputs", pack_outs(), '0);
        @(negedge clk);
        drive(idle_v);
        reset = 1'b1;

        // Table-driven vectors, checked mid-cycle before the next edge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), pack_outs(), pack_exp(vecs[i]));
        end

        // Both requesting continuously: dbg gets every 9th cycle.
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) begin
                v = idle_v;
                v.creq = 1'b1; v.caddr = 32'h10;
                v.dreq = 1'b1; v.daddr = 32'h08;
                drive(v);
            end
            #1;
            exp_g = (c % 9 == 0) ? 2'b01 : 2'b10;
            check($sformatf("starve_c%0d", c), {118'd0, core_gnt, dbg_gnt, 14'd0}, {118'd0, exp_g, 14'd0});
        end
        @(negedge clk);
        drive(idle_v);

        // Reset asserted during a locked, pending dbg read.
        @(negedge clk);
        v = idle_v;
        v.dreq = 1'b1; v.daddr = 32'h08; v.dlock = 1'b1;
        drive(v);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_midop", pack_outs(), '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        v = idle_v;
        v.creq = 1'b1; v.caddr = 32'h10; v.dlock = 1'b1;
        drive(v);
        #1;
        v.cg = 1'b1; v.men = 1'b1; v.maddr = 32'h10;
        check("post_reset_core_gnt", pack_outs(), pack_exp(v));
        @(negedge clk);
        drive(idle_v);
        #1;
        v = idle_v;
        v.crv = 1'b1; v.crd = 32'h2a;
        check("post_reset_rvalid", pack_outs(), pack_exp(v));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
